// File: rtl/fetch_sequencer_pkg.sv
// Purpose: shared types and constants for the instruction-fetch sequencer.
// Latency: n/a (declarations only).
// Backpressure: n/a.
//
// Contents: fetch FSM state enum, next-PC source enum, halt/jump opcodes
// and instruction field-slice positions.
package fetch_sequencer_pkg;

    // Fetch sequencer states.
    typedef enum logic [2:0] {
        BOOT  = 3'd0,
        RUN   = 3'd1,
        STALL = 3'd2,
        FLUSH = 3'd3,
        HALT  = 3'd4
    } fetch_state_t;

    // Source chosen for the next program counter value.
    typedef enum logic [1:0] {
        SEL_HOLD   = 2'd0,
        SEL_SEQ    = 2'd1,
        SEL_BRANCH = 2'd2,
        SEL_JUMP   = 2'd3
    } pc_sel_t;

    // Opcode that stops fetch, and the J-type opcode of the ISA.
    localparam logic [5:0] HALT_OPCODE = 6'b111111;
    localparam logic [5:0] OPCODE_J    = 6'b000010;

    // Instruction field positions.
    localparam int OPCODE_MSB = 31;
    localparam int OPCODE_LSB = 26;
    localparam int INDEX_MSB  = 25;
    localparam int INDEX_LSB  = 0;

endpackage

// File: rtl/fetch_sequencer_if.sv
// Purpose: bundles the fetch sequencer's control, memory and IF/ID signals.
// Latency: n/a (wiring only).
// Backpressure: stall travels environment -> sequencer; no ready path back.
//
// master: the fetch sequencer (drives PC, memory address and IF/ID outputs).
// slave : the surrounding pipeline/memory (drives stall, redirects, imem data).
interface fetch_sequencer_if;

    // Control inputs to the sequencer.
    logic        stall;
    logic        branch_taken;
    logic [31:0] branch_target;
    logic        jump;
    logic [25:0] jump_index;

    // Instruction memory (combinational read).
    logic [31:0] imem_instr;
    logic [31:0] imem_addr;

    // Sequencer state visible to the pipeline.
    logic [31:0] current_pc;
    logic [31:0] if_instr;
    logic [31:0] if_pc;
    logic        if_valid;
    logic        halted;
    logic [31:0] fetch_count;

    modport master (
        input  stall,
        input  branch_taken,
        input  branch_target,
        input  jump,
        input  jump_index,
        input  imem_instr,
        output imem_addr,
        output current_pc,
        output if_instr,
        output if_pc,
        output if_valid,
        output halted,
        output fetch_count
    );

    modport slave (
        output stall,
        output branch_taken,
        output branch_target,
        output jump,
        output jump_index,
        output imem_instr,
        input  imem_addr,
        input  current_pc,
        input  if_instr,
        input  if_pc,
        input  if_valid,
        input  halted,
        input  fetch_count
    );

endinterface

// File: rtl/fetch_sequencer_next_pc_sel.sv
// Purpose: combinational priority select of the next program counter.
// Latency: zero cycles (pure combinational).
// Backpressure: advance=0 with no redirect selects hold.
//
// Ports: current_pc, branch_req/branch_target, jump_req/jump_index, advance
// in; next_pc and the chosen source (sel) out. Priority: branch > jump >
// sequential > hold. Requests arrive already qualified by FSM state.
module fetch_sequencer_next_pc_sel
    import fetch_sequencer_pkg::*;
#(
    parameter int PC_INC = 4
) (
    input  logic [31:0] current_pc,
    input  logic        branch_req,
    input  logic [31:0] branch_target,
    input  logic        jump_req,
    input  logic [25:0] jump_index,
    input  logic        advance,
    output logic [31:0] next_pc,
    output pc_sel_t     sel
);

    logic [31:0] pc_seq;
    logic [31:0] jump_target;

    // Modulo-2^32 increment; wrap past 32'hFFFF_FFFC is intentional.
    assign pc_seq = current_pc + 32'(PC_INC);

    // Byte-addressed cores keep the region bits of the delay-slot PC and
    // scale the index by 4; word-addressed cores splice the index in directly.
    generate
        if (PC_INC == 4) begin : g_byte_addr
            assign jump_target = {pc_seq[31:28], jump_index[INDEX_MSB:INDEX_LSB], 2'b00};
        end else begin : g_word_addr
            assign jump_target = {current_pc[31:26], jump_index[INDEX_MSB:INDEX_LSB]};
        end
    endgenerate

    always_comb begin
        next_pc = current_pc;
        sel     = SEL_HOLD;
        if (branch_req) begin
            // Branch belongs to the older instruction, so it wins over jump.
            next_pc = branch_target;
            sel     = SEL_BRANCH;
        end else if (jump_req) begin
            next_pc = jump_target;
            sel     = SEL_JUMP;
        end else if (advance) begin
            next_pc = pc_seq;
            sel     = SEL_SEQ;
        end
    end

endmodule

// File: rtl/fetch_sequencer.sv
// Purpose: owns the PC, addresses instruction memory, captures IF/ID; handles
//          stall, one-bubble branch/jump redirect, and halt.
// Latency: word at address A appears on if_instr one edge after current_pc=A.
// Backpressure: stall freezes PC, IF/ID and fetch_count; redirects override it.
//
// Ports: clk, reset (synchronous, active-low), fif (fetch_sequencer_if.master):
//   stall, branch_taken/branch_target, jump/jump_index, imem_instr in;
//   imem_addr, current_pc, if_instr, if_pc, if_valid, halted, fetch_count out.
module fetch_sequencer
    import fetch_sequencer_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          PC_INC   = 4,
    parameter logic [5:0]  HALT_OP  = HALT_OPCODE
) (
    input  logic              clk,
    input  logic              reset,
    fetch_sequencer_if.master fif
);

    fetch_state_t state;

    logic [31:0] pc_q;
    logic [31:0] if_instr_q;
    logic [31:0] if_pc_q;
    logic        if_valid_q;
    logic        halted_q;
    logic [31:0] fetch_count_q;

    logic        branch_req;
    logic        jump_req;
    logic        advance;
    logic [31:0] next_pc;
    pc_sel_t     sel;
    logic        is_halt_word;

    // Which requests the current state is allowed to act on. BOOT ignores
    // everything; HALT only listens to branch (the halt was on a wrong path).
    assign branch_req = fif.branch_taken && (state != BOOT);
    assign jump_req   = fif.jump && (state != BOOT) && (state != HALT);
    assign advance    = !fif.stall &&
                        ((state == RUN) || (state == STALL) || (state == FLUSH));

    assign is_halt_word = (fif.imem_instr[OPCODE_MSB:OPCODE_LSB] == HALT_OP);

    fetch_sequencer_next_pc_sel #(
        .PC_INC (PC_INC)
    ) u_next_pc_sel (
        .current_pc    (pc_q),
        .branch_req    (branch_req),
        .branch_target (fif.branch_target),
        .jump_req      (jump_req),
        .jump_index    (fif.jump_index),
        .advance       (advance),
        .next_pc       (next_pc),
        .sel           (sel)
    );

    always_ff @(posedge clk) begin
        if (!reset) begin
            state         <= BOOT;
            pc_q          <= RESET_PC;
            if_instr_q    <= 32'h0;
            if_pc_q       <= 32'h0;
            if_valid_q    <= 1'b0;
            halted_q      <= 1'b0;
            fetch_count_q <= 32'h0;
        end else begin
            case (state)
                BOOT: begin
                    // One settling cycle: PC already holds RESET_PC.
                    state <= RUN;
                end
                default: begin
                    case (sel)
                        SEL_BRANCH, SEL_JUMP: begin
                            // Word currently on imem_instr is wrong-path:
                            // drop it, leaving a single bubble.
                            pc_q       <= next_pc;
                            if_valid_q <= 1'b0;
                            halted_q   <= 1'b0;
                            state      <= FLUSH;
                        end
                        SEL_SEQ: begin
                            pc_q          <= next_pc;
                            if_instr_q    <= fif.imem_instr;
                            if_pc_q       <= pc_q;
                            if_valid_q    <= 1'b1;
                            fetch_count_q <= fetch_count_q + 32'd1;
                            // The halt word itself is delivered to decode;
                            // fetching stops after it.
                            if (is_halt_word) begin
                                state    <= HALT;
                                halted_q <= 1'b1;
                            end else begin
                                state    <= RUN;
                            end
                        end
                        default: begin
                            // Hold: either parked in HALT or decode stalled.
                            if (state == HALT) begin
                                if_valid_q <= 1'b0;
                            end else begin
                                state <= STALL;
                            end
                        end
                    endcase
                end
            endcase
        end
    end

    assign fif.imem_addr   = pc_q;
    assign fif.current_pc  = pc_q;
    assign fif.if_instr    = if_instr_q;
    assign fif.if_pc       = if_pc_q;
    assign fif.if_valid    = if_valid_q;
    assign fif.halted      = halted_q;
    assign fif.fetch_count = fetch_count_q;

endmodule

// File: tb/tb_fetch_sequencer.sv
// Purpose: directed scoreboard bench for fetch_sequencer.
// Latency: expectations are for the edge following each driven vector.
// Backpressure: stall is driven directly from the vector table.
module tb_fetch_sequencer;

    localparam logic [31:0] HALT_ADDR = 32'h0000_0010;
    localparam logic [31:0] W         = 32'h0400_0000; // plain word base
    localparam logic [31:0] H         = 32'hFC00_0000; // halt word base

    typedef struct {
        string       name;
        logic [31:0] pc;
        logic        v;
        logic [31:0] ifpc;
        logic [31:0] instr;
        logic        h;
        logic [31:0] cnt;
    } exp_t;

    logic clk;
    logic reset;
    int   tests;
    int   fails;
    exp_t sb[$];

    fetch_sequencer_if fif ();

    fetch_sequencer #(
        .RESET_PC (32'h0000_0000),
        .PC_INC   (4),
        .HALT_OP  (6'b111111)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .fif   (fif)
    );

    initial clk = 1'b1;
    always #5 clk = ~clk;

    // Instruction memory: every address holds W+addr, except HALT_ADDR which
    // holds a halt-opcode word.
    always_comb begin
        if (fif.imem_addr == HALT_ADDR) fif.imem_instr = H + fif.imem_addr;
        else                            fif.imem_instr = W + fif.imem_addr;
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        tests++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s: actual=%h required=%h", nm, act, req);
        end
    endtask

    // Drive one vector before the edge and queue what must appear after it.
    task automatic step(input string nm, input logic rst, input logic stl,
                        input logic br, input logic [31:0] bt,
                        input logic jp, input logic [25:0] ji,
                        input logic [31:0] epc, input logic ev,
                        input logic [31:0] eifpc, input logic [31:0] einstr,
                        input logic eh, input logic [31:0] ecnt);
        exp_t e;
        @(negedge clk);
        reset             = rst;
        fif.stall         = stl;
        fif.branch_taken  = br;
        fif.branch_target = bt;
        fif.jump          = jp;
        fif.jump_index    = ji;
        e.name  = nm;
        e.pc    = epc;
        e.v     = ev;
        e.ifpc  = eifpc;
        e.instr = einstr;
        e.h     = eh;
        e.cnt   = ecnt;
        sb.push_back(e);
    endtask

    // Monitor: after every edge, pop the expectation and compare all outputs.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (sb.size() > 0) begin
                e = sb.pop_front();
                chk({e.name, ".current_pc"},  fif.current_pc,  e.pc);
                chk({e.name, ".imem_addr"},   fif.imem_addr,   e.pc);
                chk({e.name, ".if_valid"},    32'(fif.if_valid), 32'(e.v));
                chk({e.name, ".if_pc"},       fif.if_pc,       e.ifpc);
                chk({e.name, ".if_instr"},    fif.if_instr,    e.instr);
                chk({e.name, ".halted"},      32'(fif.halted), 32'(e.h));
                chk({e.name, ".fetch_count"}, fif.fetch_count, e.cnt);
            end
        end
    end

    initial begin
        tests = 0;
        fails = 0;
        reset = 1'b0;
        fif.stall = 1'b0;
        fif.branch_taken = 1'b0;
        fif.branch_target = 32'h0;
        fif.jump = 1'b0;
        fif.jump_index = 26'h0;

        //    name            rst stl br bt             jp ji           pc             v ifpc           instr            h cnt
        step("r00_reset",      0, 0, 0, 32'h0,         0, 26'h0,       32'h0,         0, 32'h0,         32'h0,           0, 0);
        step("r01_reset",      0, 0, 0, 32'h0,         0, 26'h0,       32'h0,         0, 32'h0,         32'h0,           0, 0);
        step("r02_boot",       1, 0, 0, 32'h0,         0, 26'h0,       32'h0,         0, 32'h0,         32'h0,           0, 0);
        step("r03_fetch0",     1, 0, 0, 32'h0,         0, 26'h0,       32'h4,         1, 32'h0,         W,               0, 1);
        step("r04_fetch4",     1, 0, 0, 32'h0,         0, 26'h0,       32'h8,         1, 32'h4,         W + 32'h4,       0, 2);
        step("r05_stall1",     1, 1, 0, 32'h0,         0, 26'h0,       32'h8,         1, 32'h4,         W + 32'h4,       0, 2);
        step("r06_stall2",     1, 1, 0, 32'h0,         0, 26'h0,       32'h8,         1, 32'h4,         W + 32'h4,       0, 2);
        step("r07_stall3",     1, 1, 0, 32'h0,         0, 26'h0,       32'h8,         1, 32'h4,         W + 32'h4,       0, 2);
        step("r08_resume8",    1, 0, 0, 32'h0,         0, 26'h0,       32'hC,         1, 32'h8,         W + 32'h8,       0, 3);
        step("r09_fetchC",     1, 0, 0, 32'h0,         0, 26'h0,       32'h10,        1, 32'hC,         W + 32'hC,       0, 4);
        // branch + jump + stall together while a halt word sits on the wrong path
        step("r10_br_jp_stl",  1, 1, 1, 32'h40,        1, 26'h3FFFFFF, 32'h40,        0, 32'hC,         W + 32'hC,       0, 4);
        step("r11_fetch40",    1, 0, 0, 32'h0,         0, 26'h0,       32'h44,        1, 32'h40,        W + 32'h40,      0, 5);
        step("r12_br1000",     1, 0, 1, 32'h1000_0010, 0, 26'h0,       32'h1000_0010, 0, 32'h40,        W + 32'h40,      0, 5);
        step("r13_jump_flush", 1, 0, 0, 32'h0,         1, 26'h10,      32'h1000_0040, 0, 32'h40,        W + 32'h40,      0, 5);
        step("r14_fetch_jt",   1, 0, 0, 32'h0,         0, 26'h0,       32'h1000_0044, 1, 32'h1000_0040, W + 32'h1000_0040, 0, 6);
        step("r15_jump_max",   1, 0, 0, 32'h0,         1, 26'h3FFFFFF, 32'h1FFF_FFFC, 0, 32'h1000_0040, W + 32'h1000_0040, 0, 6);
        step("r16_fetch_jmax", 1, 0, 0, 32'h0,         0, 26'h0,       32'h2000_0000, 1, 32'h1FFF_FFFC, W + 32'h1FFF_FFFC, 0, 7);
        step("r17_br_top",     1, 0, 1, 32'hFFFF_FFFC, 0, 26'h0,       32'hFFFF_FFFC, 0, 32'h1FFF_FFFC, W + 32'h1FFF_FFFC, 0, 7);
        step("r18_pc_wrap",    1, 0, 0, 32'h0,         0, 26'h0,       32'h0,         1, 32'hFFFF_FFFC, 32'h03FF_FFFC,   0, 8);
        step("r19_fetch0",     1, 0, 0, 32'h0,         0, 26'h0,       32'h4,         1, 32'h0,         W,               0, 9);
        step("r20_fetch4",     1, 0, 0, 32'h0,         0, 26'h0,       32'h8,         1, 32'h4,         W + 32'h4,       0, 10);
        step("r21_fetch8",     1, 0, 0, 32'h0,         0, 26'h0,       32'hC,         1, 32'h8,         W + 32'h8,       0, 11);
        step("r22_fetchC",     1, 0, 0, 32'h0,         0, 26'h0,       32'h10,        1, 32'hC,         W + 32'hC,       0, 12);
        step("r23_halt_cap",   1, 0, 0, 32'h0,         0, 26'h0,       32'h14,        1, 32'h10,        H + 32'h10,      1, 13);
        step("r24_halt_jump",  1, 0, 0, 32'h0,         1, 26'h5,       32'h14,        0, 32'h10,        H + 32'h10,      1, 13);
        step("r25_halt_stall", 1, 1, 0, 32'h0,         0, 26'h0,       32'h14,        0, 32'h10,        H + 32'h10,      1, 13);
        step("r26_halt_br0",   1, 0, 1, 32'h0,         0, 26'h0,       32'h0,         0, 32'h10,        H + 32'h10,      0, 13);
        step("r27_fetch0",     1, 0, 0, 32'h0,         0, 26'h0,       32'h4,         1, 32'h0,         W,               0, 14);
        step("r28_stall",      1, 1, 0, 32'h0,         0, 26'h0,       32'h4,         1, 32'h0,         W,               0, 14);
        step("r29_rst_stall",  0, 1, 0, 32'h0,         0, 26'h0,       32'h0,         0, 32'h0,         32'h0,           0, 0);
        step("r30_boot",       1, 0, 0, 32'h0,         0, 26'h0,       32'h0,         0, 32'h0,         32'h0,           0, 0);
        step("r31_fetch0",     1, 0, 0, 32'h0,         0, 26'h0,       32'h4,         1, 32'h0,         W,               0, 1);
        step("r32_fetch4",     1, 0, 0, 32'h0,         0, 26'h0,       32'h8,         1, 32'h4,         W + 32'h4,       0, 2);
        step("r33_fetch8",     1, 0, 0, 32'h0,         0, 26'h0,       32'hC,         1, 32'h8,         W + 32'h8,       0, 3);
        step("r34_fetchC",     1, 0, 0, 32'h0,         0, 26'h0,       32'h10,        1, 32'hC,         W + 32'hC,       0, 4);
        step("r35_halt_cap",   1, 0, 0, 32'h0,         0, 26'h0,       32'h14,        1, 32'h10,        H + 32'h10,      1, 5);
        step("r36_halt_idle",  1, 0, 0, 32'h0,         0, 26'h0,       32'h14,        0, 32'h10,        H + 32'h10,      1, 5);
        step("r37_rst_halt",   0, 0, 0, 32'h0,         0, 26'h0,       32'h0,         0, 32'h0,         32'h0,           0, 0);
        step("r38_boot",       1, 0, 0, 32'h0,         0, 26'h0,       32'h0,         0, 32'h0,         32'h0,           0, 0);
        step("r39_fetch0",     1, 0, 0, 32'h0,         0, 26'h0,       32'h4,         1, 32'h0,         W,               0, 1);

        // Let the monitor consume the last expectation, bounded by two edges.
        repeat (2) @(posedge clk);
        #2;
        chk("scoreboard_drained", 32'(sb.size()), 32'h0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
